// File: rtl/l3l4cs_axis_pkt_fifo.sv
// l3l4cs_axis_pkt_fifo
// AXI-Stream packet FIFO between two axi_stream_if endpoints in the l3l4cs
// datapath. Buffers DEPTH beats of {tlast, tuser, tdata} with show-ahead
// output and registered level/packet-count/status flags.
// Build option: define L3L4CS_AXIS_PKT_FIFO_SAF_EN for store-and-forward.
// In that mode beats are held back until a whole packet is stored. An
// oversize escape prevents deadlock: if the FIFO fills with no complete
// packet, it releases beats cut-through until the next popped tlast.
module l3l4cs_axis_pkt_fifo #(
   parameter int DWIDTH    = 76,
   parameter int UWIDTH    = 1,
   parameter int DEPTH     = 16,
   parameter int AFULL_LVL = DEPTH - 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      s_tvalid,
   output logic                      s_tready,
   input  logic [DWIDTH-1:0]         s_tdata,
   input  logic [UWIDTH-1:0]         s_tuser,
   input  logic                      s_tlast,
   output logic                      m_tvalid,
   input  logic                      m_tready,
   output logic [DWIDTH-1:0]         m_tdata,
   output logic [UWIDTH-1:0]         m_tuser,
   output logic                      m_tlast,
   output logic [$clog2(DEPTH):0]    level,
   output logic [$clog2(DEPTH):0]    pkt_cnt,
   output logic                      afull,
   output logic                      empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int EW = DWIDTH + UWIDTH + 1;

   localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
   localparam logic [LW-1:0] LVL_AFULL = LW'(AFULL_LVL);
   localparam logic [LW-1:0] LVL_ONE   = LW'(1);
   localparam logic [AW:0]   PTR_ONE   = (AW+1)'(1);

   // Entry layout: {tlast, tuser, tdata}
   logic [EW-1:0]  mem [DEPTH];
   logic [AW:0]    wr_ptr;
   logic [AW:0]    rd_ptr;
   logic [LW-1:0]  level_r;
   logic [LW-1:0]  pkt_cnt_r;
   logic [LW-1:0]  level_nxt;
   logic [LW-1:0]  pkt_cnt_nxt;
   logic           ready_r;
   logic           empty_r;
   logic           afull_r;
   logic           valid;
   logic           push;
   logic           pop;
   logic           head_last;
   logic [EW-1:0]  head;

   assign head      = mem[rd_ptr[AW-1:0]];
   assign head_last = head[EW-1];
   assign push      = s_tvalid && ready_r;
   assign pop       = valid && m_tready;

`ifdef L3L4CS_AXIS_PKT_FIFO_SAF_EN
   logic escape_r;

   // Release when a whole packet is stored, when full, or while escaping an oversize packet
   assign valid = !empty_r && ((pkt_cnt_r != '0) || (level_r == LVL_FULL) || escape_r);

   // Oversize escape: armed by a full FIFO holding no tlast, disarmed by the popped tlast
   always_ff @(posedge clk) begin
      if (reset) begin
         escape_r <= 1'b0;
      end else if (pop && head_last) begin
         escape_r <= 1'b0;
      end else if ((level_r == LVL_FULL) && (pkt_cnt_r == '0)) begin
         escape_r <= 1'b1;
      end
   end
`else
   assign valid = !empty_r;
`endif

   // Show-ahead output, forced to zero while nothing is offered
   always_comb begin
      m_tvalid = valid;
      {m_tlast, m_tuser, m_tdata} = valid ? head : '0;
   end

   assign s_tready = ready_r;
   assign level    = level_r;
   assign pkt_cnt  = pkt_cnt_r;
   assign afull    = afull_r;
   assign empty    = empty_r;

   // Next occupancy and packet count from this cycle's push/pop
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch can be inferred.
      level_nxt   = level_r;
      pkt_cnt_nxt = pkt_cnt_r;
      if (push && !pop) begin
         level_nxt = level_r + LVL_ONE;
      end else if (!push && pop) begin
         level_nxt = level_r - LVL_ONE;
      end
      if ((push && s_tlast) && !(pop && head_last)) begin
         pkt_cnt_nxt = pkt_cnt_r + LVL_ONE;
      end else if (!(push && s_tlast) && (pop && head_last)) begin
         pkt_cnt_nxt = pkt_cnt_r - LVL_ONE;
      end
   end

   // Storage write; contents are don't-care until written
   always_ff @(posedge clk) begin
      // NOTE: the beat memory has no reset; validity is tracked by the pointers and level.
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= {s_tlast, s_tuser, s_tdata};
      end
   end

   // Pointers, counters and registered status flags
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level_r   <= '0;
         pkt_cnt_r <= '0;
         ready_r   <= 1'b0;
         empty_r   <= 1'b1;
         afull_r   <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         level_r   <= level_nxt;
         pkt_cnt_r <= pkt_cnt_nxt;
         ready_r   <= (level_nxt != LVL_FULL);
         empty_r   <= (level_nxt == '0);
         afull_r   <= (level_nxt >= LVL_AFULL);
      end
   end

endmodule

// File: tb/tb_l3l4cs_axis_pkt_fifo.sv
// Directed self-checking bench for l3l4cs_axis_pkt_fifo (DEPTH=16).
// Inputs are driven and outputs sampled on the falling edge; expected
// values are hand-computed per vector.
module tb_l3l4cs_axis_pkt_fifo;

   localparam int DWIDTH = 76;
   localparam int UWIDTH = 1;
   localparam int DEPTH  = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic              s_tvalid;
   logic              s_tready;
   logic [DWIDTH-1:0] s_tdata;
   logic [UWIDTH-1:0] s_tuser;
   logic              s_tlast;
   logic              m_tvalid;
   logic              m_tready;
   logic [DWIDTH-1:0] m_tdata;
   logic [UWIDTH-1:0] m_tuser;
   logic              m_tlast;
   logic [4:0]        level;
   logic [4:0]        pkt_cnt;
   logic              afull;
   logic              empty;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   l3l4cs_axis_pkt_fifo #(
      .DWIDTH(DWIDTH), .UWIDTH(UWIDTH), .DEPTH(DEPTH), .AFULL_LVL(DEPTH-2)
   ) dut (
      .clk(clk), .reset(reset),
      .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
      .s_tuser(s_tuser), .s_tlast(s_tlast),
      .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
      .m_tuser(m_tuser), .m_tlast(m_tlast),
      .level(level), .pkt_cnt(pkt_cnt), .afull(afull), .empty(empty)
   );

   task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic [DWIDTH-1:0] d, input logic [UWIDTH-1:0] u,
                        input logic l, input logic rdy);
      s_tvalid = v;
      s_tdata  = d;
      s_tuser  = u;
      s_tlast  = l;
      m_tready = rdy;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      tick();
      tick();

      // Reset values
      check("rst_s_tready", 96'(s_tready), 96'(0));
      check("rst_m_tvalid", 96'(m_tvalid), 96'(0));
      check("rst_m_tdata",  96'(m_tdata),  96'(0));
      check("rst_m_tuser",  96'(m_tuser),  96'(0));
      check("rst_m_tlast",  96'(m_tlast),  96'(0));
      check("rst_level",    96'(level),    96'(0));
      check("rst_pkt_cnt",  96'(pkt_cnt),  96'(0));
      check("rst_afull",    96'(afull),    96'(0));
      check("rst_empty",    96'(empty),    96'(1));
      reset = 1'b0;
      tick();
      check("post_rst_s_tready", 96'(s_tready), 96'(1));
      check("post_rst_m_tvalid", 96'(m_tvalid), 96'(0));

      // Three-beat packet, cut-through, consumer always ready
      drive(1'b1, 76'h1, 1'b0, 1'b0, 1'b1);
      tick();
      check("ct_valid_lat1", 96'(m_tvalid), 96'(1));
      check("ct_data1",      96'(m_tdata),  96'(1));
      check("ct_level1",     96'(level),    96'(1));
      check("ct_empty1",     96'(empty),    96'(0));
      drive(1'b1, 76'h2, 1'b0, 1'b0, 1'b1);
      tick();
      check("ct_data2",  96'(m_tdata), 96'(2));
      check("ct_last2",  96'(m_tlast), 96'(0));
      check("ct_level2", 96'(level),   96'(1));
      drive(1'b1, 76'h3, 1'b0, 1'b1, 1'b1);
      tick();
      check("ct_data3",  96'(m_tdata), 96'(3));
      check("ct_last3",  96'(m_tlast), 96'(1));
      check("ct_level3", 96'(level),   96'(1));
      check("ct_pkt3",   96'(pkt_cnt), 96'(1));
      drive(1'b0, '0, '0, 1'b0, 1'b1);
      tick();
      check("ct_valid_end", 96'(m_tvalid), 96'(0));
      check("ct_level_end", 96'(level),    96'(0));
      check("ct_empty_end", 96'(empty),    96'(1));
      check("ct_pkt_end",   96'(pkt_cnt),  96'(0));

      // Fill to full with consumer stalled
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b1, 76'(256 + i), 1'b0, 1'b0, 1'b0);
         tick();
         check("fill_level",    96'(level),    96'(i + 1));
         check("fill_afull",    96'(afull),    96'((i + 1) >= 14));
         check("fill_s_tready", 96'(s_tready), 96'((i + 1) != DEPTH));
      end
      check("fill_head", 96'(m_tdata), 96'(256));
      drive(1'b1, 76'hBAD, 1'b0, 1'b0, 1'b0);
      tick();
      check("full_no_push", 96'(level), 96'(16));
      drive(1'b0, '0, '0, 1'b0, 1'b1);
      tick();
      check("pop_full_s_tready", 96'(s_tready), 96'(1));
      check("pop_full_level",    96'(level),    96'(15));
      check("pop_full_afull",    96'(afull),    96'(1));
      for (int i = 1; i < DEPTH; i++) begin
         check("drain_data", 96'(m_tdata), 96'(256 + i));
         tick();
      end
      check("drain_empty",  96'(empty),    96'(1));
      check("drain_valid",  96'(m_tvalid), 96'(0));
      check("drain_afull",  96'(afull),    96'(0));

      // Simultaneous push/pop at level 8 across pointer wrap
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 76'(512 + i), 1'b0, 1'b0, 1'b0);
         tick();
      end
      check("pp_level_start", 96'(level), 96'(8));
      for (int c = 0; c < 40; c++) begin
         drive(1'b1, 76'(520 + c), 1'b0, 1'b0, 1'b1);
         check("pp_data", 96'(m_tdata), 96'(512 + c));
         tick();
         check("pp_level", 96'(level), 96'(8));
      end
      drive(1'b0, '0, '0, 1'b0, 1'b1);
      for (int c = 40; c < 48; c++) begin
         check("pp_drain_data", 96'(m_tdata), 96'(512 + c));
         tick();
      end
      check("pp_empty", 96'(empty), 96'(1));

      // Output held stable under backpressure, while another beat arrives
      drive(1'b1, 76'hABC, 1'b1, 1'b1, 1'b0);
      tick();
      for (int k = 0; k < 5; k++) begin
         check("hold_valid", 96'(m_tvalid), 96'(1));
         check("hold_data",  96'(m_tdata),  96'(76'hABC));
         check("hold_user",  96'(m_tuser),  96'(1));
         check("hold_last",  96'(m_tlast),  96'(1));
         if (k == 0) drive(1'b1, 76'hDEF, 1'b0, 1'b0, 1'b0);
         else        drive(1'b0, '0, '0, 1'b0, 1'b0);
         tick();
      end
      check("hold_level", 96'(level),   96'(2));
      check("hold_pkt",   96'(pkt_cnt), 96'(1));
      drive(1'b0, '0, '0, 1'b0, 1'b1);
      tick();
      check("acc_data2", 96'(m_tdata), 96'(76'hDEF));
      check("acc_user2", 96'(m_tuser), 96'(0));
      check("acc_last2", 96'(m_tlast), 96'(0));
      check("acc_pkt2",  96'(pkt_cnt), 96'(0));
      tick();
      check("acc_empty", 96'(empty), 96'(1));

      // Reset mid-packet at level 5
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 76'(768 + i), 1'b0, (i == 2), 1'b0);
         tick();
      end
      check("mid_level", 96'(level),   96'(5));
      check("mid_pkt",   96'(pkt_cnt), 96'(1));
      reset = 1'b1;
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      tick();
      check("mrst_level",    96'(level),    96'(0));
      check("mrst_pkt",      96'(pkt_cnt),  96'(0));
      check("mrst_valid",    96'(m_tvalid), 96'(0));
      check("mrst_empty",    96'(empty),    96'(1));
      check("mrst_s_tready", 96'(s_tready), 96'(0));
      reset = 1'b0;
      tick();
      check("mrst_ready_after", 96'(s_tready), 96'(1));
      check("mrst_no_stale",    96'(m_tvalid), 96'(0));
      drive(1'b1, 76'h55, 1'b0, 1'b0, 1'b1);
      tick();
      check("after_rst_d0", 96'(m_tdata), 96'(76'h55));
      check("after_rst_l0", 96'(m_tlast), 96'(0));
      drive(1'b1, 76'h66, 1'b0, 1'b1, 1'b1);
      tick();
      check("after_rst_d1", 96'(m_tdata), 96'(76'h66));
      check("after_rst_l1", 96'(m_tlast), 96'(1));
      drive(1'b0, '0, '0, 1'b0, 1'b1);
      tick();
      check("after_rst_empty", 96'(empty), 96'(1));

`ifdef L3L4CS_AXIS_PKT_FIFO_SAF_EN
      // Store-and-forward: 4-beat packet with gaps, consumer ready throughout
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 76'(160 + i), 1'b0, 1'b0, 1'b1);
         tick();
         check("saf_hold_a", 96'(m_tvalid), 96'(0));
         drive(1'b0, '0, '0, 1'b0, 1'b1);
         tick();
         check("saf_hold_b", 96'(m_tvalid), 96'(0));
      end
      drive(1'b1, 76'(163), 1'b0, 1'b1, 1'b1);
      tick();
      check("saf_release", 96'(m_tvalid), 96'(1));
      check("saf_pkt",     96'(pkt_cnt),  96'(1));
      check("saf_level",   96'(level),    96'(4));
      drive(1'b0, '0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         check("saf_data", 96'(m_tdata), 96'(160 + i));
         tick();
      end
      check("saf_empty", 96'(empty), 96'(1));

      // Oversize packet: nothing released until full, then escape drains it
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b1, 76'(176 + i), 1'b0, 1'b0, 1'b1);
         tick();
         check("ovs_valid", 96'(m_tvalid), 96'(i == DEPTH - 1));
      end
      check("ovs_level", 96'(level),   96'(16));
      check("ovs_pkt",   96'(pkt_cnt), 96'(0));
      drive(1'b0, '0, '0, 1'b0, 1'b1);
      for (int i = 0; i < DEPTH; i++) begin
         check("ovs_esc_valid", 96'(m_tvalid), 96'(1));
         check("ovs_esc_data",  96'(m_tdata),  96'(176 + i));
         tick();
      end
      drive(1'b1, 76'hEE, 1'b0, 1'b1, 1'b1);
      tick();
      check("ovs_tail_valid", 96'(m_tvalid), 96'(1));
      check("ovs_tail_data",  96'(m_tdata),  96'(76'hEE));
      drive(1'b0, '0, '0, 1'b0, 1'b1);
      tick();
      check("ovs_tail_empty", 96'(empty), 96'(1));
      drive(1'b1, 76'h77, 1'b0, 1'b0, 1'b1);
      tick();
      check("ovs_escape_cleared", 96'(m_tvalid), 96'(0));
      drive(1'b0, '0, '0, 1'b0, 1'b1);
      tick();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
